// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: fetch-control state encodings and default sizing
package fetch_queue_pkg;
  localparam int FQ_AW = 16;
  localparam int FQ_DW = 16;
  localparam int FQ_BYTES = 2;
  localparam int FQ_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALTED} state_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request bus plus decode-side valid/ready bus
interface fetch_queue_if import fetch_queue_pkg::*; #(
  parameter int AW = FQ_AW,
  parameter int DW = FQ_DW
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic          mem_exc;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  modport master (
    output mem_req, mem_addr, out_valid, out_pc, out_inst,
    input  mem_ack, mem_data, mem_exc, out_ready
  );
  modport slave (
    input  mem_req, mem_addr, out_valid, out_pc, out_inst,
    output mem_ack, mem_data, mem_exc, out_ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: circular buffer of {pc, inst} entries; flush beats push and pop
module fetch_queue_fifo import fetch_queue_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH,
  parameter int W = FQ_AW + FQ_DW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [W-1:0]                 i_data,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push  = i_push & !o_full & !i_flush;
  assign w_pop   = i_pop & !o_empty & !i_flush;
  assign o_data  = r_mem[r_head];
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_tail] <= i_data;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch with redirect/halt flush and a
// DISCARD state that swallows the response of a request made before a flush
module fetch_queue import fetch_queue_pkg::*; #(
  parameter int INST_ADDR_WIDTH = FQ_AW,
  parameter int INST_DATA_BIT_WIDTH = FQ_DW,
  parameter int NUM_BYTES_IN_INST = FQ_BYTES,
  parameter int QUEUE_DEPTH = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  fetch_queue_if.master              io_bus,
  input  logic                       i_redirect,
  input  logic [INST_ADDR_WIDTH-1:0] i_redirect_addr,
  input  logic                       i_halt,
  output logic                       o_exc_fetch
);
  localparam int AW = INST_ADDR_WIDTH;
  localparam int DW = INST_DATA_BIT_WIDTH;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  state_t          r_state, w_state;
  logic            r_halt_pend, w_halt_pend, r_mem_req, w_mem_req, r_exc, w_exc;
  logic [AW-1:0]   r_fetch_pc, w_fetch_pc, r_mem_addr, w_mem_addr, w_pc_inc;
  logic [CW-1:0]   w_count, w_count_nxt;
  logic            w_full, w_empty, w_flush, w_push, w_pop, w_wait, w_ack;
  logic [AW+DW-1:0] w_head;
  assign w_flush     = i_halt | i_redirect;
  assign w_ack       = r_mem_req & io_bus.mem_ack;
  assign w_wait      = r_mem_req & !io_bus.mem_ack;
  assign w_push      = r_state == REQ & w_ack & !io_bus.mem_exc & !w_flush;
  assign w_pop       = !w_empty & io_bus.out_ready & !w_flush;
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
  assign w_pc_inc    = r_fetch_pc + AW'(NUM_BYTES_IN_INST);
  fetch_queue_fifo #(.DEPTH(QUEUE_DEPTH), .W(AW + DW)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_flush(w_flush),
    .i_data({r_mem_addr, io_bus.mem_data}), .o_data(w_head), .o_count(w_count),
    .o_full(w_full), .o_empty(w_empty)
  );
  always_comb begin
    w_state     = r_state;
    w_halt_pend = r_halt_pend;
    w_mem_req   = r_mem_req;
    w_mem_addr  = r_mem_addr;
    w_fetch_pc  = r_fetch_pc;
    w_exc       = r_exc;
    if (i_halt) begin
      w_halt_pend = 1'b1;
      w_mem_req   = w_wait;
      w_state     = w_wait ? DISCARD : HALTED;
    end else if (i_redirect && r_state != HALTED) begin
      w_fetch_pc = i_redirect_addr;
      w_exc      = r_state == DISCARD ? r_exc : 1'b0;
      w_mem_req  = w_wait;
      w_state    = w_wait ? DISCARD : (r_halt_pend ? HALTED : IDLE);
    end else if (r_state == IDLE) begin
      w_mem_req  = !w_full & !r_exc;
      w_mem_addr = r_fetch_pc;
      w_state    = (!w_full && !r_exc) ? REQ : IDLE;
    end else if (r_state == REQ && w_ack && io_bus.mem_exc) begin
      w_exc     = 1'b1;
      w_mem_req = 1'b0;
      w_state   = IDLE;
    end else if (r_state == REQ && w_ack) begin
      w_fetch_pc = w_pc_inc;
      w_mem_addr = w_pc_inc;
      w_mem_req  = w_count_nxt != DEPTH_C;
      w_state    = w_count_nxt != DEPTH_C ? REQ : IDLE;
    end else if (r_state == DISCARD && w_ack) begin
      w_mem_req = 1'b0;
      w_state   = r_halt_pend ? HALTED : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_halt_pend <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_fetch_pc  <= '0;
      r_exc       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_halt_pend <= w_halt_pend;
      r_mem_req   <= w_mem_req;
      r_mem_addr  <= w_mem_addr;
      r_fetch_pc  <= w_fetch_pc;
      r_exc       <= w_exc;
    end
  end
  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.out_valid = !w_empty;
  assign io_bus.out_pc    = w_empty ? '0 : w_head[AW+DW-1:DW];
  assign io_bus.out_inst  = w_empty ? '0 : w_head[DW-1:0];
  assign o_exc_fetch      = r_exc;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic against a queue-based model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        t_rst = 1'b1, t_ack = 1'b0, t_exc = 1'b0, t_redir = 1'b0, t_halt = 1'b0, t_ready = 1'b0;
  logic [15:0] t_data = '0, t_raddr = '0;
  logic        exc_fetch;
  int          n_cmp = 0, n_bad = 0;
  bit          chk_en = 0;
  logic [15:0] qpc[$], qinst[$];
  bit          m_req, m_stale, m_hp, m_halted, m_exc;
  logic [15:0] m_addr, m_pc;

  fetch_queue_if #(.AW(16), .DW(16)) bus();
  assign bus.mem_ack   = t_ack;
  assign bus.mem_data  = t_data;
  assign bus.mem_exc   = t_exc;
  assign bus.out_ready = t_ready;

  fetch_queue dut (
    .clk(clk), .rst(t_rst), .io_bus(bus), .i_redirect(t_redir),
    .i_redirect_addr(t_raddr), .i_halt(t_halt), .o_exc_fetch(exc_fetch)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] inst_of(logic [15:0] a);
    return a + 16'h1000;
  endfunction

  // model state after the edge, derived from the held inputs of that edge
  task automatic model_update();
    bit busy, full0;
    if (t_rst) begin
      qpc.delete(); qinst.delete();
      {m_req, m_stale, m_hp, m_halted, m_exc} = '0;
      m_addr = '0; m_pc = '0;
      return;
    end
    if (m_halted) return;
    busy = m_req;
    if (t_halt) begin
      qpc.delete(); qinst.delete();
      if (busy && !t_ack) begin m_stale = 1; m_hp = 1; end
      else begin m_req = 0; m_stale = 0; m_halted = 1; end
    end else if (t_redir) begin
      qpc.delete(); qinst.delete();
      m_pc = t_raddr;
      if (!m_stale) m_exc = 0;
      if (busy && !t_ack) m_stale = 1;
      else begin
        m_req = 0;
        if (m_stale && m_hp) m_halted = 1;
        m_stale = 0;
      end
    end else begin
      full0 = qpc.size() == DEPTH;
      if (qpc.size() != 0 && t_ready) begin void'(qpc.pop_front()); void'(qinst.pop_front()); end
      if (busy && t_ack) begin
        if (m_stale) begin m_stale = 0; m_req = 0; if (m_hp) m_halted = 1; end
        else if (t_exc) begin m_exc = 1; m_req = 0; end
        else begin
          qpc.push_back(m_addr); qinst.push_back(t_data);
          m_pc = m_pc + 16'd2;
          m_req = qpc.size() < DEPTH;
          m_addr = m_pc;
        end
      end else if (!busy && !m_exc && !full0) begin
        m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic step(input bit r, a, e, rd, input logic [15:0] ra, input bit h, rdy, rnd);
    t_rst = r; t_ack = a; t_exc = e; t_redir = rd; t_raddr = ra; t_halt = h; t_ready = rdy;
    t_data = rnd ? 16'($urandom) : inst_of(m_addr);
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_pc"}, bus.out_pc, 0);
    chk({tag, "_out_inst"}, bus.out_inst, 0);
    chk({tag, "_exc"}, exc_fetch, 0);
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("mem_req", bus.mem_req, m_req);
    if (m_req) chk("mem_addr", bus.mem_addr, m_addr);
    chk("out_valid", bus.out_valid, qpc.size() != 0);
    if (qpc.size() != 0) begin
      chk("out_pc", bus.out_pc, qpc[0]);
      chk("out_inst", bus.out_inst, qinst[0]);
    end
    chk("exc_fetch", exc_fetch, m_exc);
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    chk_reset_vals("rst");
    // zero-wait memory, decode always ready
    step(0, 1, 0, 0, 0, 0, 1, 0);
    chk("s1_req", bus.mem_req, 1); chk("s1_addr0", bus.mem_addr, 16'h0);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    chk("s1_addr2", bus.mem_addr, 16'h2); chk("s1_pc0", bus.out_pc, 16'h0);
    chk("s1_inst0", bus.out_inst, 16'h1000);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    chk("s1_addr4", bus.mem_addr, 16'h4); chk("s1_pc2", bus.out_pc, 16'h2);
    chk("s1_inst2", bus.out_inst, 16'h1002);
    repeat (5) step(0, 1, 0, 0, 0, 0, 1, 0);
    // decode stalled: queue fills to four entries, then resumes at 8
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("s2_model_cnt", qpc.size(), 4);
    chk("s2_req_off", bus.mem_req, 0); chk("s2_pc0", bus.out_pc, 16'h0);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    chk("s2_pc2", bus.out_pc, 16'h2); chk("s2_still_off", bus.mem_req, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    chk("s2_resume", bus.mem_req, 1); chk("s2_addr8", bus.mem_addr, 16'h8);
    // slow memory with redirect while waiting
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0040, 0, 0, 0);
    chk("s3_disc_req", bus.mem_req, 1); chk("s3_disc_addr", bus.mem_addr, 16'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("s3_stale_drop", bus.out_valid, 0); chk("s3_idle", bus.mem_req, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s3_new_addr", bus.mem_addr, 16'h0040); chk("s3_nv", bus.out_valid, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("s3_pc40", bus.out_pc, 16'h0040); chk("s3_inst40", bus.out_inst, 16'h1040);
    // redirect and halt together while a request is outstanding
    step(0, 0, 0, 1, 16'h0080, 1, 0, 0);
    chk("s4_flushed", bus.out_valid, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, i[0], 16'h0100, 0, 1, 0);
    chk("s4_halted", bus.mem_req, 0); chk("s4_nv", bus.out_valid, 0);
    // fetch exception at address 4
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, m_req && m_addr == 16'h4, 0, 0, 0, 1, 0);
    chk("s5_exc", exc_fetch, 1); chk("s5_req_off", bus.mem_req, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 1, 0);
    chk("s5_no_req", bus.mem_req, 0); chk("s5_no_pc4", bus.out_valid, 0);
    step(0, 0, 0, 1, 16'h0000, 0, 1, 0);
    chk("s5_exc_clr", exc_fetch, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("s5_refetch", bus.mem_req, 1); chk("s5_addr0", bus.mem_addr, 16'h0);
    // reset mid-request with two queued entries
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("s6_pre_req", bus.mem_req, 1); chk("s6_pre_cnt", qpc.size(), 2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_reset_vals("s6");
    // random traffic
    for (int i = 0; i < 4000; i++)
      step(m_halted ? ($urandom % 8 == 0) : ($urandom % 300 == 0),
           m_req && ($urandom % 10 < 6), $urandom % 15 == 0, $urandom % 20 == 0,
           16'($urandom) & 16'hFFFE, $urandom % 200 == 0, $urandom % 10 < 7, 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
